// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg
//   Shared definitions for the SPI register slave: FSM state encoding,
//   the RW command-bit polarity and the bit-counter width helper.
//   No ports (package).

package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // CS high, waiting for a frame
        ST_CMD  = 2'd1,   // shifting in RW + address
        ST_DATA = 2'd2,   // shifting data words
        ST_HOLD = 2'd3    // single word done, SCK ignored until CS rises
    } state_t;

    // Value of the first frame bit that marks a write frame.
    localparam logic RW_WRITE = 1'b1;

    // Counter must hold the longest phase length (command or data word).
    function automatic int cnt_width(input int addr_w, input int data_w);
        int longest;
        longest = ((1 + addr_w) > data_w) ? (1 + addr_w) : data_w;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Two-flop synchroniser for one asynchronous SPI line plus single-cycle
//   rise/fall pulses derived from the synchronised value.
// Ports
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset (flops load RST_LEVEL)
//   async_i    in   asynchronous input line
//   rise_o     out  1-cycle pulse on a synchronised 0->1 transition
//   fall_o     out  1-cycle pulse on a synchronised 1->0 transition

module spi_sync_edge #(
    parameter logic RST_LEVEL = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resetting to the line's idle level avoids a false edge after reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta_q <= RST_LEVEL;
            sync_q <= RST_LEVEL;
            prev_q <= RST_LEVEL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave
//   SPI register slave oversampled by sys_clk. Frame (MSB first):
//   RW (1 = write), ADDR[ADDR_W-1:0], then DATA_W bits per data word.
//   With BURST_EN the address auto-increments (wrapping NUM_REGS-1 -> 0)
//   for every further word while CS stays low.
// Ports
//   sys_clk, sys_rst_n  system clock, asynchronous active-low reset
//   spi_sck/cs_n/mosi   SPI inputs, asynchronous to sys_clk
//   spi_miso            read data, 0 whenever not shifting a read word
//   spi_miso_oe         MISO drive enable, high in the data phase
//   regs_o              packed register contents, reg i at [i*DATA_W +: DATA_W]
//   ro_i                status values returned for RO_MASK registers
//   wr_stb_o            per-register 1-cycle write strobe
//   frame_err_o         1-cycle pulse when CS rises in the middle of a word
//   dbg_state_o         current FSM state
// Output pulses: wr_stb_o[i] is high for exactly one sys_clk, the same cycle
// regs_o slice i first shows the new word; frame_err_o is high for exactly
// one sys_clk after an aborted word. There is no back-pressure.

module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int                         ADDR_W   = 6,
    parameter int                         DATA_W   = 16,
    parameter int                         NUM_REGS = 32,
    parameter bit                         CPOL     = 1'b0,
    parameter bit                         CPHA     = 1'b0,
    parameter bit                         BURST_EN = 1'b1,
    parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL  = '0,
    parameter logic [NUM_REGS-1:0]        RO_MASK  = '0
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         spi_sck,
    input  logic                         spi_cs_n,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    output logic                         spi_miso_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_i,
    output logic [NUM_REGS-1:0]          wr_stb_o,
    output logic                         frame_err_o,
    output state_t                       dbg_state_o
);

    localparam int CNT_W = cnt_width(ADDR_W, DATA_W);
    // Input history: enough for the address bits and DATA_W-1 data bits.
    localparam int SH_W  = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
    localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   NUM_EXT   = (ADDR_W + 1)'(NUM_REGS);

    state_t              state_q, state_d;
    logic                sck_rise, sck_fall, cs_rise, cs_fall;
    logic                lead_edge, trail_edge, samp_edge, shift_edge;
    logic                mosi_meta, mosi_s;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic [SH_W-1:0]     sh_q;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q, addr_inc, rd_addr, cmd_addr;
    logic [ADDR_W:0]     cmd_word;
    logic                cmd_rw;
    logic [DATA_W-1:0]   tx_q, rd_word, wr_word;
    logic                miso_q;
    logic                samp, cmd_done, word_done;
    logic                addr_ok, ro_hit, wr_en;
    logic [NUM_REGS-1:0] wr_stb_d;

    spi_sync_edge #(.RST_LEVEL(CPOL)) u_sck_sync (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .async_i  (spi_sck),
        .rise_o   (sck_rise),
        .fall_o   (sck_fall)
    );

    spi_sync_edge #(.RST_LEVEL(1'b1)) u_cs_sync (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .async_i  (spi_cs_n),
        .rise_o   (cs_rise),
        .fall_o   (cs_fall)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            mosi_meta <= spi_mosi;
            mosi_s    <= mosi_meta;
        end
    end

    // Leading edge leaves the idle level; CPHA picks which edge samples.
    assign lead_edge  = CPOL ? sck_fall : sck_rise;
    assign trail_edge = CPOL ? sck_rise : sck_fall;
    assign samp_edge  = CPHA ? trail_edge : lead_edge;
    assign shift_edge = CPHA ? lead_edge  : trail_edge;

    // Sample/counter decode. Samples outside CMD/DATA (CS high, HOLD) are dropped.
    always_comb begin
        samp      = samp_edge && (state_q == ST_CMD || state_q == ST_DATA);
        cmd_done  = samp && (state_q == ST_CMD)  && (cnt_q == CMD_LAST);
        word_done = samp && (state_q == ST_DATA) && (cnt_q == DATA_LAST);
        cnt_nxt   = cnt_q;
        if (cmd_done || word_done) begin
            cnt_nxt = '0;
        end else if (samp) begin
            cnt_nxt = cnt_q + 1'b1;
        end
    end

    assign cmd_word = {sh_q[ADDR_W-1:0], mosi_s};
    assign cmd_rw   = cmd_word[ADDR_W];
    assign cmd_addr = cmd_word[ADDR_W-1:0];
    assign wr_word  = {sh_q[DATA_W-2:0], mosi_s};
    assign addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
    assign addr_ok  = ({1'b0, addr_q} < NUM_EXT);
    // Word to preload for MISO: the commanded address, or the next burst address.
    assign rd_addr  = cmd_done ? cmd_addr : addr_inc;

    always_comb begin
        ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                ro_hit = RO_MASK[i];
            end
        end
        wr_en = word_done && (rw_q == RW_WRITE) && addr_ok && !ro_hit;
        wr_stb_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_stb_d[i] = wr_en && (addr_q == ADDR_W'(i));
        end
    end

    // Out-of-range addresses read as zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_word = RO_MASK[i] ? ro_i[i*DATA_W +: DATA_W] : regs_o[i*DATA_W +: DATA_W];
            end
        end
    end

    // Register bank; RO entries never see a strobe and keep their reset value.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic [DATA_W-1:0] reg_q;
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                reg_q <= RST_VAL[g*DATA_W +: DATA_W];
            end else if (wr_stb_d[g]) begin
                reg_q <= wr_word;
            end
        end
        assign regs_o[g*DATA_W +: DATA_W] = reg_q;
    end

    // FSM: state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. CS rise wins over everything but the sample in the
    // same cycle has already been accounted for by the datapath.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cs_fall)   state_d = ST_CMD;
            ST_CMD:  if (cmd_done)  state_d = ST_DATA;
            ST_DATA: if (word_done && !BURST_EN) state_d = ST_HOLD;
            default: state_d = state_q;
        endcase
        if (cs_rise) begin
            state_d = ST_IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        spi_miso_oe = (state_q == ST_DATA);
        spi_miso    = (state_q == ST_DATA && rw_q != RW_WRITE) ? miso_q : 1'b0;
        dbg_state_o = state_q;
    end

    // Datapath
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q       <= '0;
            sh_q        <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            wr_stb_o    <= '0;
            frame_err_o <= 1'b0;
        end else begin
            cnt_q <= cs_rise ? '0 : cnt_nxt;
            if (samp) begin
                sh_q <= {sh_q[SH_W-2:0], mosi_s};
            end
            // Shift and sample edges never coincide, so the preload below
            // cannot collide with a shift.
            if (state_q == ST_DATA && shift_edge) begin
                miso_q <= tx_q[DATA_W-1];
                tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
            end else if (state_q == ST_IDLE) begin
                miso_q <= 1'b0;
            end
            if (cmd_done) begin
                rw_q   <= cmd_rw;
                addr_q <= cmd_addr;
                tx_q   <= rd_word;
            end else if (word_done && BURST_EN) begin
                addr_q <= addr_inc;
                tx_q   <= rd_word;
            end
            wr_stb_o    <= wr_stb_d;
            frame_err_o <= cs_rise && (state_q == ST_CMD || state_q == ST_DATA)
                           && (cnt_nxt != '0);
        end
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave
//   Four slaves, one per CPOL/CPHA mode (index m: CPOL = m/2, CPHA = m%2),
//   driven one at a time by a bit-banged SPI master. Expected write strobes,
//   frame errors and read words go into exp_q; a negedge monitor turns DUT
//   strobes/errors and captured read words into records and compares them.

module tb_spi_reg_slave;
    import spi_reg_pkg::*;

    localparam int HALF = 8;  // SCK half period in sys_clk cycles
    localparam logic [511:0] RST_VAL = (512'h1770 << 32) | (512'h5A5A << 128);
    localparam logic [31:0]  RO_MASK = 32'h0000_0002;
    localparam logic [1:0] K_WR = 2'd1, K_ERR = 2'd2, K_RD = 2'd3;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n;
    logic [3:0]   sck;
    logic [3:0]   cs_n;
    logic         mosi;
    logic [3:0]   miso;
    logic [3:0]   miso_oe;
    logic [511:0] regs [4];
    logic [511:0] ro_i;
    logic [31:0]  wr_stb [4];
    logic [3:0]   ferr;
    state_t       dbg [4];

    logic [25:0]  exp_q[$];     // {kind, inst, addr, data}
    logic [25:0]  rd_obs_q[$];
    logic [15:0]  tx_words [4];
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_reg_slave #(
            .ADDR_W(6), .DATA_W(16), .NUM_REGS(32),
            .CPOL((g / 2) == 1), .CPHA((g % 2) == 1), .BURST_EN(1'b1),
            .RST_VAL(RST_VAL), .RO_MASK(RO_MASK)
        ) u_dut (
            .sys_clk    (sys_clk),
            .sys_rst_n  (sys_rst_n),
            .spi_sck    (sck[g]),
            .spi_cs_n   (cs_n[g]),
            .spi_mosi   (mosi),
            .spi_miso   (miso[g]),
            .spi_miso_oe(miso_oe[g]),
            .regs_o     (regs[g]),
            .ro_i       (ro_i),
            .wr_stb_o   (wr_stb[g]),
            .frame_err_o(ferr[g]),
            .dbg_state_o(dbg[g])
        );
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic exp_push(input logic [1:0] kind, input int m, input logic [5:0] addr,
                            input logic [15:0] data);
        exp_q.push_back({kind, 2'(m), addr, data});
    endtask

    task automatic sb_check(input logic [25:0] act, input string what);
        logic [25:0] exp;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event %h, required none", what, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: got %h, required %h", what, act, exp);
            end
        end
    endtask

    task automatic check(input string what, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", what, act, exp);
        end
    endtask

    // Monitor: every DUT strobe/error and every captured read word is scored.
    always @(negedge sys_clk) begin
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 32; i++) begin
                if (wr_stb[m][i]) sb_check({K_WR, 2'(m), 6'(i), regs[m][i*16 +: 16]}, "wr_stb");
            end
            if (ferr[m]) sb_check({K_ERR, 2'(m), 6'd0, 16'd0}, "frame_err");
        end
        while (rd_obs_q.size() > 0) sb_check(rd_obs_q.pop_front(), "rd_word");
    end

    // SPI master: command + n_data data bits; CS released only if end_cs.
    task automatic spi_xfer(input int m, input logic rw, input logic [5:0] addr,
                            input int n_data, input bit end_cs);
        logic [6:0]  cmd;
        logic [15:0] rx;
        logic        cpol, cpha, b;
        int          d;
        cpol = ((m / 2) == 1);
        cpha = ((m % 2) == 1);
        cmd  = {rw, addr};
        rx   = '0;
        cs_n[m] = 1'b0;
        wait_clk(HALF);
        for (int k = 0; k < 7 + n_data; k++) begin
            d = k - 7;
            if (k < 7) b = cmd[6-k];
            else       b = rw ? tx_words[d / 16][15 - (d % 16)] : 1'b0;
            if (!cpha) begin
                mosi = b;
                wait_clk(HALF);
                sck[m] = ~cpol;
                if (k >= 7) rx = {rx[14:0], miso[m]};
                wait_clk(HALF);
                sck[m] = cpol;
            end else begin
                sck[m] = ~cpol;
                mosi = b;
                wait_clk(HALF);
                sck[m] = cpol;
                if (k >= 7) rx = {rx[14:0], miso[m]};
                wait_clk(HALF);
            end
            if (k >= 7 && (d % 16) == 15 && !rw) rd_obs_q.push_back({K_RD, 2'(m), addr, rx});
        end
        wait_clk(HALF);
        if (end_cs) begin
            cs_n[m] = 1'b1;
            wait_clk(HALF);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        sck  = 4'b1100;
        cs_n = 4'hF;
        mosi = 1'b0;
        ro_i = 512'h0042 << 16;
        for (int i = 0; i < 4; i++) tx_words[i] = '0;
        wait_clk(5);
        sys_rst_n = 1'b1;
        wait_clk(5);

        // Reset state
        check("rst_regs", regs[0], RST_VAL);
        check("rst_oe", 512'(miso_oe), 512'd0);
        check("rst_miso", 512'(miso), 512'd0);
        check("rst_ferr", 512'(ferr), 512'd0);
        exp_push(K_RD, 0, 6'h02, 16'h1770);
        spi_xfer(0, 1'b0, 6'h02, 16, 1'b1);

        // All four modes: write then read back
        for (int m = 0; m < 4; m++) begin
            tx_words[0] = 16'hA5C3;
            exp_push(K_WR, m, 6'h06, 16'hA5C3);
            spi_xfer(m, 1'b1, 6'h06, 16, 1'b1);
            exp_push(K_RD, m, 6'h06, 16'hA5C3);
            spi_xfer(m, 1'b0, 6'h06, 16, 1'b1);
        end

        // Burst write wrapping 31 -> 0, then burst read of the same pair
        tx_words[0] = 16'h1111;
        tx_words[1] = 16'h2222;
        exp_push(K_WR, 0, 6'h1F, 16'h1111);
        exp_push(K_WR, 0, 6'h00, 16'h2222);
        spi_xfer(0, 1'b1, 6'h1F, 32, 1'b1);
        exp_push(K_RD, 0, 6'h1F, 16'h1111);
        exp_push(K_RD, 0, 6'h1F, 16'h2222);
        spi_xfer(0, 1'b0, 6'h1F, 32, 1'b1);

        // Read-only and out-of-range: no strobes, reads give status / zero
        tx_words[0] = 16'hFFFF;
        spi_xfer(0, 1'b1, 6'h01, 16, 1'b1);
        spi_xfer(0, 1'b1, 6'h25, 16, 1'b1);
        exp_push(K_RD, 0, 6'h01, 16'h0042);
        spi_xfer(0, 1'b0, 6'h01, 16, 1'b1);
        exp_push(K_RD, 0, 6'h3F, 16'h0000);
        spi_xfer(0, 1'b0, 6'h3F, 16, 1'b1);

        // Abort after 10 data bits, register untouched, next frames fine
        tx_words[0] = 16'hFFFF;
        exp_push(K_ERR, 0, 6'h00, 16'h0000);
        spi_xfer(0, 1'b1, 6'h08, 10, 1'b1);
        exp_push(K_RD, 0, 6'h08, 16'h5A5A);
        spi_xfer(0, 1'b0, 6'h08, 16, 1'b1);
        tx_words[0] = 16'h1234;
        exp_push(K_WR, 0, 6'h08, 16'h1234);
        spi_xfer(0, 1'b1, 6'h08, 16, 1'b1);
        exp_push(K_RD, 0, 6'h08, 16'h1234);
        spi_xfer(0, 1'b0, 6'h08, 16, 1'b1);

        // Reset in the middle of a burst write
        tx_words[0] = 16'hCAFE;
        tx_words[1] = 16'hF00D;
        exp_push(K_WR, 0, 6'h10, 16'hCAFE);
        spi_xfer(0, 1'b1, 6'h10, 24, 1'b0);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_regs", regs[0], RST_VAL);
        check("midrst_oe", 512'(miso_oe[0]), 512'd0);
        check("midrst_miso", 512'(miso[0]), 512'd0);
        check("midrst_stb", 512'(wr_stb[0]), 512'd0);
        check("midrst_state", 512'(dbg[0]), 512'(ST_IDLE));
        wait_clk(2);
        cs_n[0] = 1'b1;
        wait_clk(2);
        sys_rst_n = 1'b1;
        wait_clk(HALF);
        tx_words[0] = 16'h0BAD;
        exp_push(K_WR, 0, 6'h10, 16'h0BAD);
        spi_xfer(0, 1'b1, 6'h10, 16, 1'b1);
        exp_push(K_RD, 0, 6'h10, 16'h0BAD);
        spi_xfer(0, 1'b0, 6'h10, 16, 1'b1);

        wait_clk(20);
        check("exp_q_drained", 512'(exp_q.size()), 512'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
